// File: rtl/count_display_pkg.sv
// Shared constants and types for the two-digit multiplexed count display.
package count_display_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [1:0] ANODE_OFF  = 2'b11;
    localparam logic [1:0] ANODE_ONES = 2'b10;
    localparam logic [1:0] ANODE_TENS = 2'b01;

    // Active-low {g,f,e,d,c,b,a} patterns; entry 0 is the rightmost element.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_e;

endpackage

// File: rtl/count_display_driver_if.sv
// Bundles the counter input and the display/wrap outputs of the driver.
interface count_display_driver_if;

    logic [3:0] count;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] an;
    logic       wrap_event;
    logic       wrap_dir;

    modport master (
        output count,
        input  seg,
        input  dp,
        input  an,
        input  wrap_event,
        input  wrap_dir
    );

    modport slave (
        input  count,
        output seg,
        output dp,
        output an,
        output wrap_event,
        output wrap_dir
    );

endinterface

// File: rtl/count_display_driver_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_decoder
    import count_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i < 4'd10) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

// File: rtl/count_display_driver.sv
// Shows a 4-bit count as two multiplexed decimal digits and flashes the decimal
// point for a number of frames after the count wraps.
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int REFRESH_DIV       = 50000,
    parameter int WRAP_FLASH_FRAMES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    count_display_driver_if.slave  bus
);

    localparam int TICK_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    slot_e             slot_q, slot_d;
    logic [3:0]        snap_q, snap_d;
    logic [3:0]        prev_q;
    logic              prev_valid_q;
    logic [7:0]        flash_q, flash_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [1:0]        an_q, an_d;
    logic              wrap_event_q, wrap_event_d;
    logic              wrap_dir_q, wrap_dir_d;

    logic       tick, boundary, up_wrap, down_wrap, snap_tens;
    logic [3:0] ones, dec_digit;
    logic [6:0] dec_seg;

    assign snap_tens = (snap_q >= 4'd10);
    assign ones      = snap_tens ? (snap_q - 4'd10) : snap_q;
    // The tens digit can only ever be 1, so it shares the decoder with the ones digit.
    assign dec_digit = (slot_q == SLOT_TENS) ? 4'd1 : ones;

    seg7_decoder u_dec (
        .digit_i (dec_digit),
        .seg_o   (dec_seg)
    );

    always_comb begin
        tick         = (tick_cnt_q == TICK_W'(REFRESH_DIV - 1));
        boundary     = tick && (slot_q == SLOT_TENS);
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        slot_d       = slot_q;
        if (tick) begin
            slot_d = (slot_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
        end
        snap_d       = boundary ? bus.count : snap_q;

        up_wrap      = prev_valid_q && (prev_q == 4'hF) && (bus.count == 4'h0);
        down_wrap    = prev_valid_q && (prev_q == 4'h0) && (bus.count == 4'hF);
        wrap_event_d = up_wrap || down_wrap;
        wrap_dir_d   = wrap_event_d ? up_wrap : wrap_dir_q;

        // A wrap landing on a frame boundary reloads rather than decrements.
        flash_d      = flash_q;
        if (wrap_event_d) begin
            flash_d = 8'(WRAP_FLASH_FRAMES);
        end else if (boundary && (flash_q != 8'd0)) begin
            flash_d = flash_q - 8'd1;
        end

        an_d  = ANODE_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (slot_q == SLOT_ONES) begin
            an_d  = ANODE_ONES;
            seg_d = dec_seg;
            dp_d  = (flash_q == 8'd0);
        end else if (snap_tens) begin
            an_d  = ANODE_TENS;
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            slot_q       <= SLOT_ONES;
            snap_q       <= 4'd0;
            prev_valid_q <= 1'b0;
            flash_q      <= 8'd0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= ANODE_OFF;
            wrap_event_q <= 1'b0;
            wrap_dir_q   <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            slot_q       <= slot_d;
            snap_q       <= snap_d;
            prev_valid_q <= 1'b1;
            flash_q      <= flash_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            wrap_event_q <= wrap_event_d;
            wrap_dir_q   <= wrap_dir_d;
        end
    end

    // Previous-count sample is pure data; prev_valid gates its use after reset.
    always_ff @(posedge clk) begin
        prev_q <= bus.count;
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.wrap_event = wrap_event_q;
    assign bus.wrap_dir   = wrap_dir_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench: a time-based reference model queues expected outputs per clk,
// a negedge monitor pops and compares them against the driver.
module tb_count_display_driver;

    localparam int DIV    = 4;
    localparam int FRAMES = 2;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [1:0] an;
        logic       we;
        logic       wd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    count_display_driver_if bus();

    count_display_driver #(
        .REFRESH_DIV       (DIV),
        .WRAP_FLASH_FRAMES (FRAMES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] enc_tbl [10];
    initial begin
        enc_tbl[0] = 7'b1000000; enc_tbl[1] = 7'b1111001; enc_tbl[2] = 7'b0100100;
        enc_tbl[3] = 7'b0110000; enc_tbl[4] = 7'b0011001; enc_tbl[5] = 7'b0010010;
        enc_tbl[6] = 7'b0000010; enc_tbl[7] = 7'b1111000; enc_tbl[8] = 7'b0000000;
        enc_tbl[9] = 7'b0010000;
    end

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    // Reference model: slot and frame position derive from the number of clocks
    // since reset release; snapshot, flash and wrap history kept as plain integers.
    int         n = 0;
    int         m_snap = 0;
    int         m_prev = 0;
    bit         m_prevv = 0;
    int         m_flash = 0;
    bit         m_wdir = 0;

    always @(posedge clk) begin
        exp_t e;
        int   c;
        bit   tens_slot, boundary, up, down;
        c = int'(bus.count);
        if (reset) begin
            n = 0; m_snap = 0; m_prevv = 0; m_flash = 0; m_wdir = 0;
            e = '{seg: 7'h7F, dp: 1'b1, an: 2'b11, we: 1'b0, wd: 1'b0};
        end else begin
            n++;
            tens_slot = (((n - 1) / DIV) % 2) == 1;
            boundary  = (n % (2 * DIV)) == 0;
            if (!tens_slot) begin
                e.an  = 2'b10;
                e.seg = enc_tbl[m_snap % 10];
                e.dp  = (m_flash > 0) ? 1'b0 : 1'b1;
            end else if (m_snap >= 10) begin
                e.an = 2'b01; e.seg = enc_tbl[1]; e.dp = 1'b1;
            end else begin
                e.an = 2'b11; e.seg = 7'h7F; e.dp = 1'b1;
            end
            up   = m_prevv && m_prev == 15 && c == 0;
            down = m_prevv && m_prev == 0 && c == 15;
            e.we = up || down;
            e.wd = (up || down) ? up : m_wdir;
            m_wdir = e.wd;
            if (up || down)                 m_flash = FRAMES;
            else if (boundary && m_flash > 0) m_flash = m_flash - 1;
            if (boundary) m_snap = c;
            m_prevv = 1'b1;
        end
        m_prev = c;
        exp_q.push_back(e);
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("an",         int'(bus.an),         int'(e.an));
            check("seg",        int'(bus.seg),        int'(e.seg));
            check("dp",         int'(bus.dp),         int'(e.dp));
            check("wrap_event", int'(bus.wrap_event), int'(e.we));
            check("wrap_dir",   int'(bus.wrap_dir),   int'(e.wd));
        end
    end

    task automatic drive(input bit r, input int c, input int cycles);
        reset     = r;
        bus.count = 4'(c);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int cur;
        reset     = 1'b1;
        bus.count = 4'd7;
        drive(1, 7, 3);
        drive(0, 7, 2);
        drive(0, 12, 24);
        drive(0, 5, 24);
        drive(0, 15, 6);
        drive(0, 0, 40);
        drive(0, 15, 5);
        drive(0, 0, 8);
        drive(0, 15, 30);
        drive(1, 0, 2);
        drive(0, 15, 3);
        drive(0, 14, 10);
        drive(0, 3, 18);
        drive(0, 4, 20);
        drive(0, 15, 3);
        drive(0, 0, 6);
        drive(1, 0, 1);
        drive(0, 0, 12);
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)      cur = $urandom_range(0, 15);
            else if (r < 20) cur = (cur + 1) % 16;
            else if (r < 30) cur = (cur + 15) % 16;
            else if (r < 33) cur = (cur == 0) ? 15 : 0;
            drive(($urandom_range(0, 399) == 0), cur, 1);
        end
        drive(0, cur, 2);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
